// File: rtl/toggle_rr_arbiter.sv
// toggle_rr_arbiter: round-robin owner of a shared toggle element's T input.
// Define TOGGLE_CNT_EN to add the toggle_cnt success counter (CNT_W bits).
module toggle_rr_arbiter #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 2
`ifdef TOGGLE_CNT_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            err_clr,
  input  logic            q_in,
  output logic [NREQ-1:0] gnt,
  output logic            t_out,
  output logic            done,
  output logic            q_snap,
  output logic            busy,
  output logic            err
`ifdef TOGGLE_CNT_EN
  ,
  output logic [CNT_W-1:0] toggle_cnt
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_SETTLE,
    ST_CHECK
  } state_t;

  state_t          state, state_d;
  logic [IW-1:0]   last, last_d;
  logic [IW-1:0]   win, win_d;
  logic [IW-1:0]   pick;
  logic [IW:0]     cand;
  logic            found;
  logic [SW-1:0]   cnt, cnt_d;
  logic            q_before, qb_d;
  logic [NREQ-1:0] gnt_d;
  logic            t_d;
  logic            done_d;
  logic            q_snap_d;
  logic            err_d;
  logic            chk_edge;

  // round-robin search: first set req bit after last, wrapping
  always_comb begin
    pick  = last;
    found = 1'b0;
    cand  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last} + (IW+1)'(i);
      if (cand >= (IW+1)'(NREQ))
        cand = cand - (IW+1)'(NREQ);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

  // the edge that leaves SETTLE is where Q is judged
  assign chk_edge = (state == ST_SETTLE) && (cnt == '0);

  // next-state and next-output logic
  always_comb begin
    state_d  = state;
    last_d   = last;
    win_d    = win;
    cnt_d    = cnt;
    qb_d     = q_before;
    gnt_d    = gnt;
    t_d      = 1'b0;
    done_d   = 1'b0;
    q_snap_d = q_snap;
    err_d    = err_clr ? 1'b0 : err;
    unique case (state)
      ST_IDLE: begin
        if (|req) begin
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick;
          win_d   = pick;
          qb_d    = q_in;
          t_d     = 1'b1;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        cnt_d   = SW'(SETTLE - 1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          q_snap_d = q_in;
          done_d   = 1'b1;
          state_d  = ST_CHECK;
          if (q_in == q_before)
            err_d = 1'b1;
        end else begin
          cnt_d = cnt - SW'(1);
        end
      end
      ST_CHECK: begin
        gnt_d   = '0;
        last_d  = win;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last     <= IW'(NREQ - 1);
      win      <= '0;
      cnt      <= '0;
      q_before <= 1'b0;
      gnt      <= '0;
      t_out    <= 1'b0;
      done     <= 1'b0;
      q_snap   <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_d;
      last     <= last_d;
      win      <= win_d;
      cnt      <= cnt_d;
      q_before <= qb_d;
      gnt      <= gnt_d;
      t_out    <= t_d;
      done     <= done_d;
      q_snap   <= q_snap_d;
      err      <= err_d;
    end
  end

  assign busy = (state != ST_IDLE);

`ifdef TOGGLE_CNT_EN
  // count completions where Q really flipped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      toggle_cnt <= '0;
    else if (chk_edge && (q_in != q_before))
      toggle_cnt <= toggle_cnt + CNT_W'(1);
  end
`else
  logic unused_chk;
  assign unused_chk = chk_edge;
`endif

endmodule

// File: tb/tb_toggle_rr_arbiter.sv
// tb_toggle_rr_arbiter: directed + random transactions vs a
// transaction-level model of the arbiter and a behavioural toggle latch.
module tb_toggle_rr_arbiter;

  localparam int NREQ   = 4;
  localparam int SETTLE = 2;

  logic            clk     = 1'b0;
  logic            rst_n   = 1'b0;
  logic [NREQ-1:0] req     = '0;
  logic            err_clr = 1'b0;
  logic            q_in;
  logic [NREQ-1:0] gnt;
  logic            t_out;
  logic            done;
  logic            q_snap;
  logic            busy;
  logic            err;
`ifdef TOGGLE_CNT_EN
  logic [1:0]      toggle_cnt;
`endif

  logic stuck   = 1'b0;
  logic latch_q = 1'b0;

  assign q_in = latch_q;

  always #5 clk = ~clk;

  // external T flip-flop; can be made to ignore T
  always @(posedge clk)
    if (t_out && !stuck)
      latch_q <= ~latch_q;

  toggle_rr_arbiter #(
    .NREQ   (NREQ),
    .SETTLE (SETTLE)
`ifdef TOGGLE_CNT_EN
    ,
    .CNT_W  (2)
`endif
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .err_clr (err_clr),
    .q_in    (q_in),
    .gnt     (gnt),
    .t_out   (t_out),
    .done    (done),
    .q_snap  (q_snap),
    .busy    (busy),
    .err     (err)
`ifdef TOGGLE_CNT_EN
    ,
    .toggle_cnt (toggle_cnt)
`endif
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         last_m = NREQ - 1;
  logic       mq = 1'b0;
  logic       err_m = 1'b0;
  logic       qs_m = 1'b0;
  logic [1:0] cnt_m = 2'd0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int lst, input logic [NREQ-1:0] r);
    for (int i = 1; i <= NREQ; i++)
      if (r[(lst + i) % NREQ])
        return (lst + i) % NREQ;
    return -1;
  endfunction

  task automatic chk_cnt(input string tag);
`ifdef TOGGLE_CNT_EN
    chk(tag, 32'(toggle_cnt), 32'(cnt_m));
`else
    if (tag.len() < 0) n_cmp++;
`endif
  endtask

  task automatic idle_cycle();
    req = '0;
    @(negedge clk);
    chk("idle_gnt", 32'(gnt), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_done", 32'(done), 0);
    chk("idle_t", 32'(t_out), 0);
  endtask

  task automatic clr_pulse();
    req     = '0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    err_m   = 1'b0;
    chk("clr_err", 32'(err), 32'(err_m));
    chk("clr_busy", 32'(busy), 0);
  endtask

  // one full transaction, entered and left at a negedge in IDLE
  task automatic txn(input logic [NREQ-1:0] r, input logic stk,
                     input logic clr_at_chk, input logic drop);
    int              w;
    logic [NREQ-1:0] oh;
    logic            qb;
    logic            det;
    if (r == '0) begin
      idle_cycle();
      return;
    end
    stuck = stk;
    req   = r;
    w     = rr_pick(last_m, r);
    oh    = NREQ'(1) << w;
    @(negedge clk);
    chk("pulse_gnt", 32'(gnt), 32'(oh));
    chk("pulse_t", 32'(t_out), 1);
    chk("pulse_busy", 32'(busy), 1);
    chk("pulse_done", 32'(done), 0);
    if (drop) req = '0;
    for (int c = 1; c <= SETTLE; c++) begin
      @(negedge clk);
      chk("settle_gnt", 32'(gnt), 32'(oh));
      chk("settle_t", 32'(t_out), 0);
      chk("settle_done", 32'(done), 0);
      chk("settle_err", 32'(err), 32'(err_m));
    end
    if (clr_at_chk) err_clr = 1'b1;
    qb  = mq;
    if (!stk) mq = ~mq;
    det = (mq == qb);
    err_m = det ? 1'b1 : (clr_at_chk ? 1'b0 : err_m);
    qs_m  = mq;
    if (!det) cnt_m = cnt_m + 2'd1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("check_done", 32'(done), 1);
    chk("check_gnt", 32'(gnt), 32'(oh));
    chk("check_qsnap", 32'(q_snap), 32'(qs_m));
    chk("check_err", 32'(err), 32'(err_m));
    chk("check_busy", 32'(busy), 1);
    chk_cnt("check_cnt");
    last_m = w;
    @(negedge clk);
    chk("end_gnt", 32'(gnt), 0);
    chk("end_done", 32'(done), 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_qsnap", 32'(q_snap), 32'(qs_m));
  endtask

  initial begin
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_t", 32'(t_out), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_qsnap", 32'(q_snap), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    chk_cnt("rst_cnt");
    rst_n = 1'b1;
    @(negedge clk);

    // single requester, Q alternates
    repeat (3) txn(4'b0001, 1'b0, 1'b0, 1'b0);
    // all requesting: rotation
    repeat (8) txn(4'b1111, 1'b0, 1'b0, 1'b0);
    // wrap and skip
    txn(4'b0100, 1'b0, 1'b0, 1'b0);
    txn(4'b0011, 1'b0, 1'b0, 1'b0);
    txn(4'b0011, 1'b0, 1'b0, 1'b0);

    // stuck latch, sticky err, clear, coincident set/clear
    txn(4'b0100, 1'b1, 1'b0, 1'b0);
    txn(4'b0100, 1'b0, 1'b0, 1'b0);
    clr_pulse();
    txn(4'b0100, 1'b1, 1'b0, 1'b0);
    txn(4'b0100, 1'b1, 1'b1, 1'b0);
    clr_pulse();

    // request dropped in PULSE still completes, then no grant
    txn(4'b1010, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    idle_cycle();

    // reset while in SETTLE, with err set beforehand
    txn(4'b0001, 1'b1, 1'b0, 1'b0);
    stuck = 1'b0;
    req   = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    mq    = ~mq;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_t", 32'(t_out), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_err", 32'(err), 0);
    last_m = NREQ - 1;
    err_m  = 1'b0;
    qs_m   = 1'b0;
    cnt_m  = 2'd0;
    req    = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (SETTLE + 2) idle_cycle();
    txn(4'b1111, 1'b0, 1'b0, 1'b0);

    // five successful toggles (counter wraps at 4)
    cnt_m = cnt_m;
    repeat (5) txn(4'b0010, 1'b0, 1'b0, 1'b0);

    // random traffic
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 5) == 0)
        clr_pulse();
      txn(NREQ'($urandom_range(0, 15)),
          ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 1) == 1));
    end
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/toggle_rr_arbiter.md
Name: toggle_rr_arbiter

Overview:
- Shares one external toggle storage element (T input, Q output) between NREQ requesters.
- Each granted requester gets exactly one single-cycle T pulse.
- After the pulse, the block waits a settle window and then checks that Q actually flipped.
- It returns the new Q value with a done pulse and keeps a sticky error flag. It sits between requester logic and the toggle element, and is the only driver of that element's T input.

Parameters:
NREQ, 4, number of requesters (2..16)
SETTLE, 2, cycles waited after the T pulse before sampling Q (1..15)
CNT_W, 16, width of toggle counter (optional feature only)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  level request per requester; held until its done
err_clr  input  1  synchronous clear of err
q_in  input  1  Q from the shared toggle element
gnt  output  NREQ  one-hot grant, registered, held for whole transaction
t_out  output  1  T drive to the toggle element, registered
done  output  1  one-cycle completion pulse
q_snap  output  1  Q sampled at completion, held until next completion
busy  output  1  high whenever state != IDLE
err  output  1  sticky: a granted toggle did not change Q
toggle_cnt  output  CNT_W  successful toggles (only with TOGGLE_CNT_EN)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=IDLE; gnt=0, t_out=0, done=0, q_snap=0, busy=0, err=0.
  - Round-robin pointer last=NREQ-1; settle counter=0; q_before=0.
- Reset mid-transaction: everything above returns to reset values immediately. No done is emitted for the aborted grant.
- FSM states: IDLE, PULSE, SETTLE, CHECK.
- IDLE:
  - If req != 0 at a rising edge, select the winner by round-robin: first set bit searching from (last+1) mod NREQ upward, with wrap.
  - At that edge: gnt <= onehot(winner), q_before <= q_in, t_out <= 1, state <= PULSE.
  - If req == 0: stay in IDLE.
- PULSE:
  - Lasts exactly 1 cycle. t_out is high only in this cycle.
  - Next edge: t_out <= 0, counter <= SETTLE-1, state <= SETTLE.
- SETTLE:
  - Lasts SETTLE cycles. Counter decrements each edge.
  - At the edge where counter==0, the block enters CHECK and in the same edge:
    - q_snap <= q_in
    - done <= 1
    - if q_in == q_before then err <= 1
- CHECK:
  - 1 cycle. done and gnt are high in this cycle.
  - Next edge: done <= 0, gnt <= 0, last <= winner, state <= IDLE.
- Latency:
  - req sampled at edge k gives gnt/t_out high from edge k.
  - done is high for the cycle after edge k+1+SETTLE.
- Throughput: minimum grant-to-grant spacing is SETTLE+3 cycles. IDLE always lasts at least one cycle between transactions.
- req handling:
  - A requester that drops req mid-transaction does not abort it; the transaction completes normally.
  - New or changed req bits are ignored outside IDLE.
- Fairness: with all requesters continuously active, grants rotate 0,1,2,...,NREQ-1,0. No requester waits more than NREQ-1 transactions.
- err_clr:
  - Clears err at the next edge.
  - If err_clr and an error detection occur at the same edge, set wins.
- q_snap changes only at completion edges.

Optional Feature:
- Macro: TOGGLE_CNT_EN.
- Defined:
  - Adds output toggle_cnt, reset to 0.
  - Increments by 1 at each completion edge where Q flipped (no err detection).
  - Wraps modulo 2^CNT_W.
  - err_clr does not affect toggle_cnt.
- Undefined: port toggle_cnt is absent and no counter logic is generated. All other behaviour is identical.

Test Plan:
- Single requester, NREQ=4, SETTLE=2, model latch flips Q on t_out. Stimulus: req=0001 held at Q=0. Required response:
  - gnt=0001
  - exactly one t_out pulse per transaction
  - done every 5 cycles
  - q_snap alternates 1,0,1
  - err stays 0
- Round-robin: req=1111 held for 8 transactions. Required response: gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000.
- Wrap and skip: after a grant to requester 2, apply req=0011. Required response: next grant is 0001, then 0010.
- Stuck latch: model ignores T and holds Q=0. Stimulus: req=0100. Required response:
  - done pulses with q_snap=0
  - err=1 and stays 1 across further transactions
  - err_clr pulse clears it
  - err_clr coincident with another failed check leaves err=1
- Reset mid-operation: assert rst_n=0 in the SETTLE state. Required response:
  - gnt, t_out, done, busy and err all 0 immediately
  - no done after release
  - with req=1111, the first grant after reset is 0001
- Request drop and counter: drop req in PULSE. Required response:
  - transaction still completes with done
  - no new grant follows
  - with TOGGLE_CNT_EN defined and CNT_W=2, five successful toggles give toggle_cnt=1 (wrap)
